// File: rtl/cu_read_command_arbiter_pkg.sv
// Shared CU read-command definitions: command/response line formats, buffer
// status, arbiter state encoding and tag-pool sizing defaults.
package cu_read_command_arbiter_pkg;

  localparam int CU_TAG_WIDTH       = 8;
  localparam int CU_MAX_OUTSTANDING = 32;

  typedef enum logic [1:0] {
    ARB_DISABLED = 2'd0,
    ARB_RUN      = 2'd1,
    ARB_DRAIN    = 2'd2
  } arbiter_state_t;

  typedef logic [$clog2(CU_MAX_OUTSTANDING+1)-1:0] tag_count_t;

  typedef struct packed {
    logic                    valid;
    logic [7:0]              cmd_code;
    logic [31:0]             address;
    logic [11:0]             size;
    logic [CU_TAG_WIDTH-1:0] tag;
  } command_buffer_line_t;

  typedef struct packed {
    logic                    valid;
    logic [CU_TAG_WIDTH-1:0] tag;
  } response_buffer_line_t;

  typedef struct packed {
    logic alfull;
  } buffer_status_t;

endpackage

// File: rtl/cu_round_robin_arbiter.sv
// Generic round-robin arbiter: one-hot combinational grant, search starting at
// a pointer that advances past the winner only when a grant is made.
module cu_round_robin_arbiter #(
  parameter int NUM_REQUESTERS = 3
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic [NUM_REQUESTERS-1:0] request,
  output logic [NUM_REQUESTERS-1:0] grant
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             found;
  int               idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQUESTERS;
        if (!found && request[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = PTR_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge rstn) begin
    if (rstn) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (int'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/cu_read_command_arbiter.sv
// Shares the CAPI read command buffer among CU request sources, stamping each
// issued command with the lowest free tag and tracking reads until they return.
module cu_read_command_arbiter
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS  = 3,
  parameter int MAX_OUTSTANDING = CU_MAX_OUTSTANDING,
  parameter int TAG_WIDTH       = CU_TAG_WIDTH
) (
  input  logic                                 clock,
  input  logic                                 rstn,
  input  logic                                 enabled,
  input  command_buffer_line_t                 command_request_in [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0]            command_grant_out,
  input  response_buffer_line_t                read_response_in,
  input  buffer_status_t                       command_buffer_status,
  output command_buffer_line_t                 command_out,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count_out,
  output logic                                 idle_out,
  output logic                                 tag_error_out
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  arbiter_state_t             state;
  arbiter_state_t             state_next;
  logic [MAX_OUTSTANDING-1:0] in_use;
  logic [CNT_W-1:0]           count;
  logic [NUM_REQUESTERS-1:0]  request_vec;
  logic [IDX_W-1:0]           alloc_idx;
  logic [TAG_WIDTH-1:0]       alloc_tag;
  logic                       pool_free;
  logic                       issue_enable;
  logic                       issue;
  command_buffer_line_t       granted_cmd;
  logic [IDX_W-1:0]           rsp_idx;
  logic                       rsp_in_range;
  logic                       release_ok;
  logic                       tag_bad;

  always_comb begin
    request_vec = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      request_vec[i] = command_request_in[i].valid;
    end
  end

  // Lowest-index free tag; allocation sees the bitmap before this cycle's release.
  always_comb begin
    alloc_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!in_use[i]) begin
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign alloc_tag    = TAG_WIDTH'(alloc_idx);
  assign pool_free    = ~&in_use;
  assign issue_enable = (state == ARB_RUN) && !command_buffer_status.alfull && pool_free;

  cu_round_robin_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_rr_arbiter (
    .clock  (clock),
    .rstn   (rstn),
    .enable (issue_enable),
    .request(request_vec),
    .grant  (command_grant_out)
  );

  assign issue = |command_grant_out;

  always_comb begin
    granted_cmd = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (command_grant_out[i]) begin
        granted_cmd = command_request_in[i];
      end
    end
  end

  assign rsp_idx      = IDX_W'(read_response_in.tag);
  assign rsp_in_range = int'(read_response_in.tag) < MAX_OUTSTANDING;
  assign release_ok   = read_response_in.valid && rsp_in_range && in_use[rsp_idx];
  assign tag_bad      = read_response_in.valid && !release_ok;

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_DISABLED: if (enabled) state_next = ARB_RUN;
      ARB_RUN:      if (!enabled) state_next = ARB_DRAIN;
      ARB_DRAIN: begin
        if (enabled)           state_next = ARB_RUN;
        else if (count == '0)  state_next = ARB_DISABLED;
      end
      default:                 state_next = ARB_DISABLED;
    endcase
  end

  // Release and allocate always touch different bits, so both apply in one edge.
  always_ff @(posedge clock or posedge rstn) begin
    if (rstn) begin
      state         <= ARB_DISABLED;
      in_use        <= '0;
      count         <= '0;
      command_out   <= '0;
      tag_error_out <= 1'b0;
    end else begin
      state <= state_next;
      if (release_ok) in_use[rsp_idx]   <= 1'b0;
      if (issue)      in_use[alloc_idx] <= 1'b1;
      unique case ({issue, release_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (tag_bad) tag_error_out <= 1'b1;
      if (issue) begin
        command_out       <= granted_cmd;
        command_out.valid <= 1'b1;
        command_out.tag   <= CU_TAG_WIDTH'(alloc_tag);
      end else begin
        command_out <= '0;
      end
    end
  end

  assign outstanding_count_out = count;
  assign idle_out              = (state == ARB_DISABLED) && (count == '0);

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Directed table-driven bench for cu_read_command_arbiter; a default instance
// and a MAX_OUTSTANDING=4 instance share one set of stimulus signals.
module tb_cu_read_command_arbiter;
  import cu_read_command_arbiter_pkg::*;

  localparam int N = 3;

  typedef struct {
    bit         d4;
    bit         rst;
    bit         en;
    bit   [2:0] req;
    bit         af;
    bit         rv;
    bit   [7:0] rtag;
    logic [2:0] exp_grant;
    logic       exp_cv;
    logic [7:0] exp_ctag;
    logic [5:0] exp_cnt;
    logic       exp_idle;
    logic       exp_err;
  } vec_t;

  logic                  clock = 1'b0;
  logic                  rstn  = 1'b1;
  logic                  enabled = 1'b0;
  command_buffer_line_t  command_request_in [N];
  response_buffer_line_t read_response_in;
  buffer_status_t        command_buffer_status;

  logic [N-1:0]          grant_a, grant_b;
  command_buffer_line_t  cmd_a, cmd_b;
  logic [5:0]            cnt_a;
  logic [2:0]            cnt_b;
  logic                  idle_a, idle_b, err_a, err_b;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  cu_read_command_arbiter dut (
    .clock                (clock),
    .rstn                 (rstn),
    .enabled              (enabled),
    .command_request_in   (command_request_in),
    .command_grant_out    (grant_a),
    .read_response_in     (read_response_in),
    .command_buffer_status(command_buffer_status),
    .command_out          (cmd_a),
    .outstanding_count_out(cnt_a),
    .idle_out             (idle_a),
    .tag_error_out        (err_a)
  );

  cu_read_command_arbiter #(.MAX_OUTSTANDING(4)) dut4 (
    .clock                (clock),
    .rstn                 (rstn),
    .enabled              (enabled),
    .command_request_in   (command_request_in),
    .command_grant_out    (grant_b),
    .read_response_in     (read_response_in),
    .command_buffer_status(command_buffer_status),
    .command_out          (cmd_b),
    .outstanding_count_out(cnt_b),
    .idle_out             (idle_b),
    .tag_error_out        (err_b)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(bit d4, bit rst, bit en, bit [2:0] req, bit af, bit rv,
                              bit [7:0] rtag, logic [2:0] g, logic cv, logic [7:0] ct,
                              logic [5:0] cnt, logic idle, logic err);
    vec_t v;
    v.d4 = d4; v.rst = rst; v.en = en; v.req = req; v.af = af; v.rv = rv; v.rtag = rtag;
    v.exp_grant = g; v.exp_cv = cv; v.exp_ctag = ct; v.exp_cnt = cnt;
    v.exp_idle = idle; v.exp_err = err;
    return v;
  endfunction

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    rstn    = v.rst;
    enabled = v.en;
    for (int i = 0; i < N; i++) begin
      command_request_in[i].valid    = v.req[i];
      command_request_in[i].cmd_code = 8'h10 + 8'(i);
      command_request_in[i].address  = 32'h1000 * (i + 1);
      command_request_in[i].size     = 12'd64;
      command_request_in[i].tag      = 8'hFF;
    end
    command_buffer_status.alfull = v.af;
    read_response_in.valid = v.rv;
    read_response_in.tag   = v.rtag;
  endtask

  task automatic checkOutput(int row, vec_t v);
    command_buffer_line_t c;
    int src;
    c = v.d4 ? cmd_b : cmd_a;
    src = 0;
    for (int i = 0; i < N; i++) if (v.exp_grant[i]) src = i;
    checkValue($sformatf("row%0d cmd_valid", row), 32'(c.valid), 32'(v.exp_cv));
    checkValue($sformatf("row%0d cmd_tag", row), 32'(c.tag), 32'(v.exp_ctag));
    if (v.exp_cv) begin
      checkValue($sformatf("row%0d cmd_address", row), c.address, 32'h1000 * (src + 1));
      checkValue($sformatf("row%0d cmd_code", row), 32'(c.cmd_code), 32'h10 + src);
    end
    checkValue($sformatf("row%0d count", row), v.d4 ? 32'(cnt_b) : 32'(cnt_a), 32'(v.exp_cnt));
    checkValue($sformatf("row%0d idle", row), 32'(v.d4 ? idle_b : idle_a), 32'(v.exp_idle));
    checkValue($sformatf("row%0d tag_error", row), 32'(v.d4 ? err_b : err_a), 32'(v.exp_err));
  endtask

  initial begin
    bit seen_idle;
    applyStimulus(mk(0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Reset state of both instances.
    repeat (2) @(negedge clock);
    checkValue("reset grant", 32'(grant_a), 0);
    checkValue("reset cmd", 32'(cmd_a.valid), 0);
    checkValue("reset count", 32'(cnt_a), 0);
    checkValue("reset idle", 32'(idle_a), 1);
    checkValue("reset tag_error", 32'(err_a), 0);
    checkValue("reset4 idle", 32'(idle_b), 1);

    // Single request, then round-robin fill and alfull hold.
    vecs.push_back(mk(0,1,0,3'b000,0,0,0, 3'b000,0,0,0,1,0));
    vecs.push_back(mk(0,0,1,3'b000,0,0,0, 3'b000,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,3'b010,0,0,0, 3'b010,1,0,1,0,0));
    vecs.push_back(mk(0,1,0,3'b000,0,0,0, 3'b000,0,0,0,1,0));
    vecs.push_back(mk(0,0,1,3'b000,0,0,0, 3'b000,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,3'b111,0,0,0, 3'b001,1,0,1,0,0));
    vecs.push_back(mk(0,0,1,3'b111,0,0,0, 3'b010,1,1,2,0,0));
    vecs.push_back(mk(0,0,1,3'b111,0,0,0, 3'b100,1,2,3,0,0));
    vecs.push_back(mk(0,0,1,3'b111,0,0,0, 3'b001,1,3,4,0,0));
    vecs.push_back(mk(0,0,1,3'b111,0,0,0, 3'b010,1,4,5,0,0));
    vecs.push_back(mk(0,0,1,3'b111,0,0,0, 3'b100,1,5,6,0,0));
    vecs.push_back(mk(0,0,1,3'b000,0,0,0, 3'b000,0,0,6,0,0));
    vecs.push_back(mk(0,0,1,3'b101,1,0,0, 3'b000,0,0,6,0,0));
    vecs.push_back(mk(0,0,1,3'b101,1,0,0, 3'b000,0,0,6,0,0));
    vecs.push_back(mk(0,0,1,3'b101,1,0,0, 3'b000,0,0,6,0,0));
    vecs.push_back(mk(0,0,1,3'b101,0,0,0, 3'b001,1,6,7,0,0));
    // Drain, stray response and sticky error.
    vecs.push_back(mk(0,1,0,3'b000,0,0,0, 3'b000,0,0,0,1,0));
    vecs.push_back(mk(0,0,1,3'b000,0,0,0, 3'b000,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,3'b001,0,0,0, 3'b001,1,0,1,0,0));
    vecs.push_back(mk(0,0,1,3'b100,0,0,0, 3'b100,1,1,2,0,0));
    vecs.push_back(mk(0,0,0,3'b000,0,0,0, 3'b000,0,0,2,0,0));
    vecs.push_back(mk(0,0,0,3'b111,0,0,0, 3'b000,0,0,2,0,0));
    vecs.push_back(mk(0,0,0,3'b000,0,1,1, 3'b000,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,3'b000,0,1,0, 3'b000,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,3'b000,0,0,0, 3'b000,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,3'b000,0,1,5, 3'b000,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,3'b000,0,0,0, 3'b000,0,0,0,1,1));
    vecs.push_back(mk(0,0,1,3'b010,0,0,0, 3'b000,0,0,0,0,1));
    vecs.push_back(mk(0,0,1,3'b010,0,0,0, 3'b010,1,0,1,0,1));
    // Reset mid-operation discards the in-flight tag.
    vecs.push_back(mk(0,1,0,3'b000,0,0,0, 3'b000,0,0,0,1,0));
    vecs.push_back(mk(0,0,1,3'b000,0,0,0, 3'b000,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,3'b001,0,0,0, 3'b001,1,0,1,0,0));
    vecs.push_back(mk(0,1,0,3'b000,0,0,0, 3'b000,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,3'b000,0,1,0, 3'b000,0,0,0,1,1));
    // Four-tag pool: full, release, release-with-issue, out-of-range tag.
    vecs.push_back(mk(1,1,0,3'b000,0,0,0, 3'b000,0,0,0,1,0));
    vecs.push_back(mk(1,0,1,3'b000,0,0,0, 3'b000,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,3'b111,0,0,0, 3'b001,1,0,1,0,0));
    vecs.push_back(mk(1,0,1,3'b111,0,0,0, 3'b010,1,1,2,0,0));
    vecs.push_back(mk(1,0,1,3'b111,0,0,0, 3'b100,1,2,3,0,0));
    vecs.push_back(mk(1,0,1,3'b111,0,0,0, 3'b001,1,3,4,0,0));
    vecs.push_back(mk(1,0,1,3'b111,0,0,0, 3'b000,0,0,4,0,0));
    vecs.push_back(mk(1,0,1,3'b111,0,1,2, 3'b000,0,0,3,0,0));
    vecs.push_back(mk(1,0,1,3'b111,0,0,0, 3'b010,1,2,4,0,0));
    vecs.push_back(mk(1,0,1,3'b111,0,1,0, 3'b000,0,0,3,0,0));
    vecs.push_back(mk(1,0,1,3'b111,0,0,0, 3'b100,1,0,4,0,0));
    vecs.push_back(mk(1,0,1,3'b000,0,1,4, 3'b000,0,0,4,0,1));

    @(negedge clock);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkValue($sformatf("row%0d grant", i), 32'(vecs[i].d4 ? grant_b : grant_a),
                 32'(vecs[i].exp_grant));
      @(negedge clock);
      checkOutput(i, vecs[i]);
    end

    // Drain to idle with a bounded wait.
    applyStimulus(mk(0,1,0,3'b000,0,0,0, 0,0,0,0,0,0));
    @(negedge clock);
    applyStimulus(mk(0,0,1,3'b000,0,0,0, 0,0,0,0,0,0));
    @(negedge clock);
    applyStimulus(mk(0,0,1,3'b001,0,0,0, 0,0,0,0,0,0));
    @(negedge clock);
    applyStimulus(mk(0,0,0,3'b000,0,0,0, 0,0,0,0,0,0));
    @(negedge clock);
    checkValue("drain busy", 32'(idle_a), 0);
    applyStimulus(mk(0,0,0,3'b000,0,1,0, 0,0,0,0,0,0));
    @(negedge clock);
    applyStimulus(mk(0,0,0,3'b000,0,0,0, 0,0,0,0,0,0));
    seen_idle = 1'b0;
    for (int k = 0; k < 10 && !seen_idle; k++) begin
      @(negedge clock);
      seen_idle = idle_a;
    end
    checkValue("drain reaches idle", 32'(seen_idle), 1);
    checkValue("drain count", 32'(cnt_a), 0);
    checkValue("drain tag_error", 32'(err_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_read_command_arbiter.md
# cu_read_command_arbiter

Shares the single CAPI read command buffer between the compute unit's request sources: vertex fetch, edge fetch and data fetch. It grants one request per cycle in round-robin order, stamps each issued command with a unique free tag, and tracks outstanding reads until their responses return. It enforces an outstanding-read ceiling and back-pressure from the command buffer. It sits between the CU request generators and the AFU command path.

## Interface
- NUM_REQUESTERS, default 3: number of request sources; index 0 has first priority after reset.
- MAX_OUTSTANDING, default 32: tag pool size; must be ≤ 2^TAG_WIDTH.
- TAG_WIDTH, default 8: width of the command/response tag field.
- clock  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-high reset. The name is kept for port-list consistency with sibling CU blocks.
- enabled  in  1  arbitration enable from the CU.
- command_request_in  in  NUM_REQUESTERS × CommandBufferLine  per-requester command; the `.valid` field is the request.
- command_grant_out  out  NUM_REQUESTERS  one-hot grant, combinational, same cycle as the accepted request.
- read_response_in  in  ResponseBufferLine  `.valid` plus `.tag` identify a completed read.
- command_buffer_status  in  BufferStatus  `.alfull` blocks issue.
- command_out  out  CommandBufferLine  registered issued command with `.tag` overwritten.
- outstanding_count_out  out  $clog2(MAX_OUTSTANDING+1)  tags currently in use.
- idle_out  out  1  high in DISABLED with zero outstanding.
- tag_error_out  out  1  sticky; set when a response arrives with a tag not in use.

## Operation
- States: DISABLED, RUN, DRAIN.
  - DISABLED→RUN when enabled=1.
  - RUN→DRAIN when enabled=0.
  - DRAIN→DISABLED when outstanding=0.
  - DRAIN→RUN if enabled returns to 1 before the drain completes.
- Issue condition, all required: state=RUN, at least one request valid, alfull=0, and at least one free tag.
- Arbitration: round-robin. Search starts at rr_ptr. On a grant to index i, rr_ptr←(i+1) mod NUM_REQUESTERS. rr_ptr is unchanged when nothing is granted.
- Requesters hold `.valid` and payload until granted. An ungranted request is not consumed.
- Tag pool: a MAX_OUTSTANDING-bit in-use bitmap. Allocation takes the lowest-index free bit.
- On a response with valid=1 whose tag is in use, that bit clears. A tag ≥ MAX_OUTSTANDING or a bit already clear sets tag_error_out; the bitmap is unchanged.
- Simultaneous release and allocate: allocation uses the bitmap before the release, so a freed tag is allocatable from the next cycle. Both updates apply in the same edge; the count changes by 0 net.
- outstanding_count_out is a counter kept equal to the bitmap popcount: +1 on issue, −1 on valid release.
- Responses are processed in every state, including DISABLED and DRAIN.

## Timing
- Grant: combinational from command_request_in, rr_ptr, bitmap, alfull and state.
- command_out: valid one cycle after the grant, carrying the granted payload plus the allocated tag. `.valid`=0 in non-issue cycles.
- Peak throughput: one command per cycle.
- alfull is sampled in the grant cycle. Asserting it blocks grants in that same cycle.
- Full pool (count=MAX_OUTSTANDING): no grant. The first grant is possible the cycle after a release.
- Reset values:
  - state=DISABLED, rr_ptr=0, bitmap=0, count=0.
  - command_out all-zero, grants=0, tag_error_out=0.
  - idle_out=1.
- Reset mid-operation: in-flight tags are discarded with no drain. Responses arriving after reset for discarded tags set tag_error_out.

## Structure
- Shared package additions in CU_PKG:
  - arbiter state enum (DISABLED/RUN/DRAIN);
  - the tag-count type;
  - the MAX_OUTSTANDING default constant.
- Sub-module: cu_round_robin_arbiter (parameter NUM_REQUESTERS; request vector in, one-hot grant out, enable input, pointer update on grant). It is reusable by the future write-command path.
- The tag bitmap and priority encoder stay in this block.

## Test plan
- Reset, then enabled=1, alfull=0, one request on requester 1 → grant=3'b010 in the same cycle; command_out.valid=1 next cycle with tag=0; count=1.
- All 3 requesters valid continuously for 6 cycles → grants 001,010,100,001,010,100; tags 0–5; count=6.
- MAX_OUTSTANDING=4: issue 4, hold requests → no grant. Return tag 2 → grant the following cycle with tag=2.
- Release tag 0 and issue in the same cycle with tags 0–3 in use and MAX=4 → no grant that cycle; count goes 4→3. Next cycle grant with tag 0.
- alfull=1 for 3 cycles with requests pending → zero grants and rr_ptr held. alfull=0 → grant resumes at the held pointer.
- enabled=0 with 2 outstanding → state DRAIN, no grants. Two responses → DISABLED and idle_out=1. A response with an unused tag → tag_error_out=1, which holds until reset.
